// File: rtl/wb_arbiter.sv
// Write-back arbiter for the register-file write port: the ALU has priority,
// multi-cycle results queue in a FIFO and a starvation counter forces them out.
module wb_arbiter #(
  parameter int DEPTH        = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     alu_valid,
  input  logic [4:0]               alu_rd,
  input  logic [31:0]              alu_data,
  input  logic                     mdu_valid,
  input  logic [4:0]               mdu_rd,
  input  logic [31:0]              mdu_data,
  output logic                     mdu_ready,
  output logic                     alu_stall,
  output logic [4:0]               rd,
  output logic [31:0]              writedata,
  output logic                     regwrite,
  output logic [$clog2(DEPTH):0]   fifo_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int SW = $clog2(STARVE_LIMIT + 1);

  localparam logic [CW-1:0] FULL_COUNT  = CW'(DEPTH);
  localparam logic [SW-1:0] STARVE_LAST = SW'(STARVE_LIMIT - 1);

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
  } wb_entry_t;

  wb_entry_t       mem_q [DEPTH];
  wb_entry_t       head;

  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic [SW-1:0]   starve_q, starve_d;
  logic            stall_q, stall_d;
  logic [4:0]      rd_q, rd_d;
  logic [31:0]     wdata_q, wdata_d;
  logic            regwrite_q, regwrite_d;

  logic            alu_req;
  logic            grant_alu;
  logic            fifo_empty;
  logic            push;
  logic            pop;

  // Push is refused when full even if a pop frees a slot on the same edge,
  // which keeps mdu_ready a pure function of registered state.
  assign mdu_ready  = (count_q != FULL_COUNT);
  assign fifo_empty = (count_q == '0);
  assign alu_req    = alu_valid && (alu_rd != '0);
  assign grant_alu  = alu_req && !stall_q;
  assign pop        = !grant_alu && !fifo_empty;
  assign push       = mdu_valid && mdu_ready && (mdu_rd != '0);
  assign head       = mem_q[rd_ptr_q];

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    starve_d   = '0;
    stall_d    = 1'b0;
    rd_d       = rd_q;
    wdata_d    = wdata_q;
    regwrite_d = 1'b0;

    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;

    unique case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    if (grant_alu) begin
      rd_d       = alu_rd;
      wdata_d    = alu_data;
      regwrite_d = 1'b1;
    end else if (pop) begin
      rd_d       = head.rd;
      wdata_d    = head.data;
      regwrite_d = 1'b1;
    end

    // Counter only runs while a queued entry is being passed over by the ALU.
    if (grant_alu && !fifo_empty) begin
      if (starve_q == STARVE_LAST) begin
        stall_d = 1'b1;
      end else begin
        starve_d = starve_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      starve_q   <= '0;
      stall_q    <= 1'b0;
      rd_q       <= '0;
      wdata_q    <= '0;
      regwrite_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      starve_q   <= starve_d;
      stall_q    <= stall_d;
      rd_q       <= rd_d;
      wdata_q    <= wdata_d;
      regwrite_q <= regwrite_d;
    end
  end

  // NOTE: storage is deliberately not reset; only slots between the pointers
  // are ever read, and resetting the pointers empties the queue.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= '{rd: mdu_rd, data: mdu_data};
  end

  assign alu_stall  = stall_q;
  assign rd         = rd_q;
  assign writedata  = wdata_q;
  assign regwrite   = regwrite_q;
  assign fifo_count = count_q;

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter: reset, ALU priority, FIFO fill/drain,
// starvation stall, contract violation and reset while entries are queued.
module tb_wb_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        alu_valid;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;
  logic        mdu_valid;
  logic [4:0]  mdu_rd;
  logic [31:0] mdu_data;
  logic        mdu_ready;
  logic        alu_stall;
  logic [4:0]  rd;
  logic [31:0] writedata;
  logic        regwrite;
  logic [2:0]  fifo_count;

  int n_checks = 0;
  int n_fail   = 0;

  wb_arbiter #(.DEPTH(4), .STARVE_LIMIT(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .alu_valid  (alu_valid),
    .alu_rd     (alu_rd),
    .alu_data   (alu_data),
    .mdu_valid  (mdu_valid),
    .mdu_rd     (mdu_rd),
    .mdu_data   (mdu_data),
    .mdu_ready  (mdu_ready),
    .alu_stall  (alu_stall),
    .rd         (rd),
    .writedata  (writedata),
    .regwrite   (regwrite),
    .fifo_count (fifo_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    alu_valid = 1'b0;
    alu_rd    = '0;
    alu_data  = '0;
    mdu_valid = 1'b0;
    mdu_rd    = '0;
    mdu_data  = '0;
  endtask

  initial begin
    // Reset with random inputs.
    reset     = 1'b1;
    alu_valid = 1'($urandom);
    alu_rd    = 5'($urandom);
    alu_data  = $urandom;
    mdu_valid = 1'($urandom);
    mdu_rd    = 5'($urandom);
    mdu_data  = $urandom;
    tick();
    tick();
    check("rst_regwrite", regwrite, 0);
    check("rst_rd", rd, 0);
    check("rst_writedata", writedata, 0);
    check("rst_stall", alu_stall, 0);
    check("rst_count", fifo_count, 0);
    check("rst_ready", mdu_ready, 1);
    reset = 1'b0;
    idle_inputs();
    tick();
    check("idle_regwrite", regwrite, 0);

    // ALU only.
    alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'h1234;
    tick();
    check("alu_regwrite", regwrite, 1);
    check("alu_rd", rd, 5);
    check("alu_data", writedata, 32'h1234);
    alu_rd = 5'd0; alu_data = 32'h9999;
    tick();
    check("alu_r0_regwrite", regwrite, 0);
    check("alu_r0_rd_hold", rd, 5);
    check("alu_r0_data_hold", writedata, 32'h1234);

    // ALU and MDU on the same edge.
    alu_rd = 5'd3; alu_data = 32'hA;
    mdu_valid = 1'b1; mdu_rd = 5'd7; mdu_data = 32'hB;
    tick();
    check("sim_rd0", rd, 3);
    check("sim_data0", writedata, 32'hA);
    check("sim_count0", fifo_count, 1);
    idle_inputs();
    tick();
    check("sim_rd1", rd, 7);
    check("sim_data1", writedata, 32'hB);
    check("sim_regwrite1", regwrite, 1);
    check("sim_count1", fifo_count, 0);
    tick();
    check("sim_regwrite2", regwrite, 0);

    // Fill the FIFO under a continuous ALU stream.
    alu_valid = 1'b1; alu_rd = 5'd20; mdu_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      alu_data = 32'hA0 + 32'(i);
      mdu_rd   = 5'(10 + i);
      mdu_data = 32'h100 + 32'(i);
      tick();
      check("fill_count", fifo_count, 64'(i + 1));
      check("fill_wdata", writedata, 64'(32'hA0 + i));
      check("fill_stall", alu_stall, 0);
    end
    check("full_ready", mdu_ready, 0);
    mdu_rd = 5'd14; mdu_data = 32'h104;
    for (int k = 5; k <= 9; k++) begin
      alu_data = 32'hA0 + 32'(k - 1);
      tick();
      check("full_count", fifo_count, 4);
      check("full_ready_hold", mdu_ready, 0);
      check("full_rd", rd, 20);
      check("full_wdata", writedata, 64'(32'hA0 + k - 1));
      check("full_stall", alu_stall, 64'(k == 9));
    end
    // Stall honoured: the head pops, the held fifth result is still refused.
    alu_valid = 1'b0;
    tick();
    check("stallpop_rd", rd, 10);
    check("stallpop_data", writedata, 32'h100);
    check("stallpop_count", fifo_count, 3);
    check("stallpop_stall", alu_stall, 0);
    check("stallpop_ready", mdu_ready, 1);
    alu_valid = 1'b1; alu_data = 32'hB0;
    tick();
    check("fifth_count", fifo_count, 4);
    check("fifth_rd", rd, 20);
    check("fifth_data", writedata, 32'hB0);
    idle_inputs();
    for (int j = 0; j < 4; j++) begin
      tick();
      check("drain_regwrite", regwrite, 1);
      check("drain_rd", rd, 64'(11 + j));
      check("drain_data", writedata, 64'(32'h101 + j));
    end
    check("drain_count", fifo_count, 0);
    tick();
    check("drain_idle", regwrite, 0);

    // Starvation with a single queued entry.
    alu_valid = 1'b1; alu_rd = 5'd21; alu_data = 32'hD0;
    mdu_valid = 1'b1; mdu_rd = 5'd7; mdu_data = 32'hC0;
    tick();
    check("starve_count0", fifo_count, 1);
    check("starve_rd0", rd, 21);
    mdu_valid = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      alu_data = 32'hD0 + 32'(k);
      tick();
      check("starve_rd", rd, 21);
      check("starve_data", writedata, 64'(32'hD0 + k));
      check("starve_count", fifo_count, 1);
      check("starve_stall", alu_stall, 64'(k == 8));
    end
    // ALU keeps asserting during the stall: FIFO wins, ALU result dropped.
    alu_rd = 5'd22; alu_data = 32'hEE;
    tick();
    check("viol_rd", rd, 7);
    check("viol_data", writedata, 32'hC0);
    check("viol_count", fifo_count, 0);
    check("viol_stall", alu_stall, 0);
    tick();
    check("resume_rd", rd, 22);
    check("resume_data", writedata, 32'hEE);
    check("resume_stall", alu_stall, 0);

    // Reset with three entries queued.
    alu_rd = 5'd23; mdu_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      alu_data = 32'hE0 + 32'(i);
      mdu_rd   = 5'(1 + i);
      mdu_data = 32'h301 + 32'(i);
      tick();
    end
    check("preq_count", fifo_count, 3);
    idle_inputs();
    reset = 1'b1;
    tick();
    check("mrst_count", fifo_count, 0);
    check("mrst_regwrite", regwrite, 0);
    check("mrst_rd", rd, 0);
    check("mrst_ready", mdu_ready, 1);
    reset = 1'b0;
    for (int j = 0; j < 5; j++) begin
      tick();
      check("post_regwrite", regwrite, 0);
      check("post_rd", rd, 0);
      check("post_count", fifo_count, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
